// File: rtl/and_serial_n.sv
// and_serial_n: bit-serial N-bit bitwise AND engine.
// Both operands are latched on an accepted start. One bit per clock is
// evaluated through a single 1-bit AND, LSB first. The result is rebuilt in a
// parallel register. A one-cycle done pulse marks completion.
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset
//   start - operation request, accepted only while idle
//   a, b  - N-bit operands, captured on the accepted start edge
//   s     - N-bit result register, filled LSB first
//   busy  - high while bits are being evaluated
//   done  - single-cycle completion pulse
//   zero  - final result was all zeros; updated together with done
module and_serial_n #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] s,
  output logic         busy,
  output logic         done,
  output logic         zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [N-1:0]  s_q, s_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          zero_q, zero_d;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    zero_d  = zero_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          s_d     = {N{1'b0}};
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The single AND stage: only the bit selected by cnt is written.
        for (int i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) begin
            s_d[i] = a_q[i] & b_q[i];
          end else begin
            s_d[i] = s_q[i];
          end
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          // Flag is taken from the completed result, including the last bit.
          zero_d  = (s_d == {N{1'b0}});
        end else begin
          cnt_d  = cnt_q + CW'(1);
          busy_d = 1'b1;
        end
      end
      DONE: begin
        // start is deliberately not looked at here.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CW{1'b0}};
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      s_q     <= {N{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      zero_q  <= zero_d;
    end
  end

  assign s    = s_q;
  assign busy = busy_q;
  assign done = done_q;
  assign zero = zero_q;

endmodule
